// File: rtl/id_ctrl_stage_if.sv
// Handshake and decode-bundle signals between IF/ID, the decode stage and ID/EX.
interface id_ctrl_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_RegWrite;
    logic            out_MemWrite;
    logic            out_ALUSrc;
    logic            out_MemtoReg;
    logic            out_jal;
    logic            out_jalr;
    logic            out_branch;
    logic [5:0]      out_IMMOp;
    logic [4:0]      out_ALUOp;
    logic [1:0]      out_WDSel;
    logic [2:0]      out_DMSize;
    logic            out_illegal;

    // Environment side: feeds instructions and consumes the bundle.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
        input  out_RegWrite, out_MemWrite, out_ALUSrc, out_MemtoReg,
        input  out_jal, out_jalr, out_branch, out_IMMOp, out_ALUOp,
        input  out_WDSel, out_DMSize, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
        output out_RegWrite, out_MemWrite, out_ALUSrc, out_MemtoReg,
        output out_jal, out_jalr, out_branch, out_IMMOp, out_ALUOp,
        output out_WDSel, out_DMSize, out_illegal
    );
endinterface

// File: rtl/id_ctrl_stage.sv
// Registered RV32I(M) decode stage: control decode, valid/ready register slice,
// load-use bubble insertion, flush and illegal-instruction flagging.
module id_ctrl_stage #(
    parameter int PC_W          = 32,
    parameter int ENABLE_M      = 1,
    parameter int HAZARD_DETECT = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    id_ctrl_stage_if.slave   bus,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [5:0] IMM_SH = 6'b100000;
    localparam logic [5:0] IMM_I  = 6'b010000;
    localparam logic [5:0] IMM_S  = 6'b001000;
    localparam logic [5:0] IMM_B  = 6'b000100;
    localparam logic [5:0] IMM_U  = 6'b000010;
    localparam logic [5:0] IMM_J  = 6'b000001;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       jal;
        logic       jalr;
        logic       branch;
        logic [5:0] imm_op;
        logic [4:0] alu_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_size;
        logic       illegal;
    } ctrl_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    ctrl_t           ctrl_d, ctrl_q;
    logic            legal, rd_zero;
    logic [4:0]      rd_d;
    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic            uses_rs1, uses_rs2, hz, take;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];

    // Combinational control decode of the offered instruction.
    always_comb begin
        ctrl_d  = '0;
        legal   = 1'b1;
        rd_zero = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
                ctrl_d.imm_op = IMM_U;   ctrl_d.alu_op = 5'd1;
            end
            OP_AUIPC: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
                ctrl_d.imm_op = IMM_U;   ctrl_d.alu_op = 5'd2;
            end
            OP_JAL: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.jal = 1'b1;
                ctrl_d.imm_op = IMM_J;   ctrl_d.alu_op = 5'd3; ctrl_d.wd_sel = 2'b10;
            end
            OP_JALR: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.jalr = 1'b1;
                ctrl_d.imm_op = IMM_I;   ctrl_d.alu_op = 5'd3; ctrl_d.wd_sel = 2'b10;
                legal = (funct3 == 3'b000);
            end
            OP_BRANCH: begin
                ctrl_d.branch = 1'b1; ctrl_d.imm_op = IMM_B; rd_zero = 1'b1;
                case (funct3)
                    3'b000:  ctrl_d.alu_op = 5'd4;
                    3'b001:  ctrl_d.alu_op = 5'd5;
                    3'b100:  ctrl_d.alu_op = 5'd6;
                    3'b101:  ctrl_d.alu_op = 5'd7;
                    3'b110:  ctrl_d.alu_op = 5'd8;
                    3'b111:  ctrl_d.alu_op = 5'd9;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.imm_op = IMM_I;   ctrl_d.alu_op = 5'd3;  ctrl_d.wd_sel = 2'b01;
                case (funct3)
                    3'b000:  ctrl_d.dm_size = 3'b011;
                    3'b001:  ctrl_d.dm_size = 3'b001;
                    3'b010:  ctrl_d.dm_size = 3'b000;
                    3'b100:  ctrl_d.dm_size = 3'b100;
                    3'b101:  ctrl_d.dm_size = 3'b010;
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1;
                ctrl_d.imm_op = IMM_S;   ctrl_d.alu_op = 5'd3; rd_zero = 1'b1;
                case (funct3)
                    3'b000:  ctrl_d.dm_size = 3'b011;
                    3'b001:  ctrl_d.dm_size = 3'b001;
                    3'b010:  ctrl_d.dm_size = 3'b000;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.imm_op = IMM_I;
                case (funct3)
                    3'b000: ctrl_d.alu_op = 5'd3;
                    3'b010: ctrl_d.alu_op = 5'd10;
                    3'b011: ctrl_d.alu_op = 5'd11;
                    3'b100: ctrl_d.alu_op = 5'd12;
                    3'b110: ctrl_d.alu_op = 5'd13;
                    3'b111: ctrl_d.alu_op = 5'd14;
                    3'b001: begin
                        ctrl_d.imm_op = IMM_SH; ctrl_d.alu_op = 5'd15;
                        legal = (funct7 == 7'b0000000);
                    end
                    default: begin
                        ctrl_d.imm_op = IMM_SH;
                        if (funct7 == 7'b0000000)      ctrl_d.alu_op = 5'd16;
                        else if (funct7 == 7'b0100000) ctrl_d.alu_op = 5'd17;
                        else                           legal = 1'b0;
                    end
                endcase
            end
            OP_REG: begin
                ctrl_d.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  ctrl_d.alu_op = 5'd3;
                            3'b001:  ctrl_d.alu_op = 5'd15;
                            3'b010:  ctrl_d.alu_op = 5'd10;
                            3'b011:  ctrl_d.alu_op = 5'd11;
                            3'b100:  ctrl_d.alu_op = 5'd12;
                            3'b101:  ctrl_d.alu_op = 5'd16;
                            3'b110:  ctrl_d.alu_op = 5'd13;
                            default: ctrl_d.alu_op = 5'd14;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      ctrl_d.alu_op = 5'd4;
                        else if (funct3 == 3'b101) ctrl_d.alu_op = 5'd17;
                        else                       legal = 1'b0;
                    end
                    7'b0000001: begin
                        if (ENABLE_M != 0) ctrl_d.alu_op = 5'd18 + {2'b00, funct3};
                        else               legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // An illegal word carries only the trap flag; downstream must not act on it.
        if (!legal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
        end
        rd_d = (legal && rd_zero) ? 5'd0 : rd;
    end

    // Load-use detection against the load currently held in the output register.
    always_comb begin
        uses_rs1 = (opcode == OP_REG) || (opcode == OP_LOAD) || (opcode == OP_IMM) ||
                   (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JALR);
        uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        hz = (HAZARD_DETECT != 0) && bus.in_valid && valid_q && ctrl_q.mem_to_reg &&
             (rd_q != 5'd0) &&
             ((uses_rs1 && (rs1 == rd_q)) || (uses_rs2 && (rs2 == rd_q)));
    end

    assign bus.in_ready = flush | ((~valid_q | bus.out_ready) & ~hz);
    assign take         = bus.in_valid & bus.in_ready;

    // Output register: flush clears, transfer-in loads, drain leaves a bubble, stall holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0; pc_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0; ctrl_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0; pc_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0; ctrl_q <= '0;
        end else if (take) begin
            valid_q <= 1'b1; pc_q <= bus.in_pc; rs1_q <= rs1; rs2_q <= rs2;
            rd_q <= rd_d; ctrl_q <= ctrl_d;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0; pc_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0; ctrl_q <= '0;
        end
    end

    // Saturating count of bubbles inserted for load-use hazards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            bubble_cnt <= '0;
        else if (!flush && hz && bus.out_ready && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_rs1      = rs1_q;
    assign bus.out_rs2      = rs2_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_RegWrite = ctrl_q.reg_write;
    assign bus.out_MemWrite = ctrl_q.mem_write;
    assign bus.out_ALUSrc   = ctrl_q.alu_src;
    assign bus.out_MemtoReg = ctrl_q.mem_to_reg;
    assign bus.out_jal      = ctrl_q.jal;
    assign bus.out_jalr     = ctrl_q.jalr;
    assign bus.out_branch   = ctrl_q.branch;
    assign bus.out_IMMOp    = ctrl_q.imm_op;
    assign bus.out_ALUOp    = ctrl_q.alu_op;
    assign bus.out_WDSel    = ctrl_q.wd_sel;
    assign bus.out_DMSize   = ctrl_q.dm_size;
    assign bus.out_illegal  = ctrl_q.illegal;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: two instances (M enabled / 16-bit counter, M disabled /
// 2-bit counter) share one stimulus stream and are compared against a table-driven
// instruction model plus a cycle-level register-slice model.
module tb_id_ctrl_stage;
    localparam int C_U = 0, C_J = 1, C_JR = 2, C_B = 3, C_L = 4, C_S = 5,
                   C_I = 6, C_SH = 7, C_R = 8, C_M = 9;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_LW0   = 32'h0000A003;
    localparam logic [31:0] I_ADD6  = 32'h00228333;
    localparam logic [31:0] I_ADDX0 = 32'h00200333;
    localparam logic [31:0] I_MUL   = 32'h022083B3;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          alu;
        int          cls;
        logic [2:0]  dm;
    } op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        regw, memw, alusrc, memtoreg, jal, jalr, branch;
        logic [5:0]  imm;
        logic [4:0]  alu;
        logic [1:0]  wd;
        logic [2:0]  dm;
        logic        ill;
    } bund_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_vec = 0;
    int n_err = 0;

    op_t   optab[$];
    logic  m_valid[2];
    bund_t m_b[2];
    int    m_cnt[2];
    int    cnt_max[2] = '{65535, 3};
    bit    en_m[2]    = '{1'b1, 1'b0};

    logic [71:0] obs_v[2];
    logic        obs_rdy[2];
    logic [15:0] obs_cnt[2];

    always #5 clk = ~clk;

    id_ctrl_stage_if #(.PC_W(32)) ifa ();
    id_ctrl_stage_if #(.PC_W(32)) ifb ();

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.in_instr = in_instr;  assign ifb.in_instr = in_instr;
    assign ifa.in_pc = in_pc;        assign ifb.in_pc = in_pc;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    id_ctrl_stage #(.PC_W(32), .ENABLE_M(1), .HAZARD_DETECT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(ifa), .bubble_cnt(cnt_a));
    id_ctrl_stage #(.PC_W(32), .ENABLE_M(0), .HAZARD_DETECT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(ifb), .bubble_cnt(cnt_b));

    assign obs_v[0] = {ifa.out_valid, ifa.out_pc, ifa.out_rs1, ifa.out_rs2, ifa.out_rd,
                       ifa.out_RegWrite, ifa.out_MemWrite, ifa.out_ALUSrc, ifa.out_MemtoReg,
                       ifa.out_jal, ifa.out_jalr, ifa.out_branch, ifa.out_IMMOp,
                       ifa.out_ALUOp, ifa.out_WDSel, ifa.out_DMSize, ifa.out_illegal};
    assign obs_v[1] = {ifb.out_valid, ifb.out_pc, ifb.out_rs1, ifb.out_rs2, ifb.out_rd,
                       ifb.out_RegWrite, ifb.out_MemWrite, ifb.out_ALUSrc, ifb.out_MemtoReg,
                       ifb.out_jal, ifb.out_jalr, ifb.out_branch, ifb.out_IMMOp,
                       ifb.out_ALUOp, ifb.out_WDSel, ifb.out_DMSize, ifb.out_illegal};
    assign obs_rdy[0] = ifa.in_ready;
    assign obs_rdy[1] = ifb.in_ready;
    assign obs_cnt[0] = cnt_a;
    assign obs_cnt[1] = {14'd0, cnt_b};

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_op(input logic [31:0] mask, input logic [31:0] match,
                          input int alu, input int cls, input logic [2:0] dm);
        op_t o;
        o.mask = mask; o.match = match; o.alu = alu; o.cls = cls; o.dm = dm;
        optab.push_back(o);
    endtask

    task automatic build_table();
        add_op(32'h7F, 32'h37, 1, C_U, 0);
        add_op(32'h7F, 32'h17, 2, C_U, 0);
        add_op(32'h7F, 32'h6F, 3, C_J, 0);
        add_op(32'h707F, 32'h67, 3, C_JR, 0);
        add_op(32'h707F, 32'h0063, 4, C_B, 0);
        add_op(32'h707F, 32'h1063, 5, C_B, 0);
        add_op(32'h707F, 32'h4063, 6, C_B, 0);
        add_op(32'h707F, 32'h5063, 7, C_B, 0);
        add_op(32'h707F, 32'h6063, 8, C_B, 0);
        add_op(32'h707F, 32'h7063, 9, C_B, 0);
        add_op(32'h707F, 32'h0003, 3, C_L, 3'b011);
        add_op(32'h707F, 32'h1003, 3, C_L, 3'b001);
        add_op(32'h707F, 32'h2003, 3, C_L, 3'b000);
        add_op(32'h707F, 32'h4003, 3, C_L, 3'b100);
        add_op(32'h707F, 32'h5003, 3, C_L, 3'b010);
        add_op(32'h707F, 32'h0023, 3, C_S, 3'b011);
        add_op(32'h707F, 32'h1023, 3, C_S, 3'b001);
        add_op(32'h707F, 32'h2023, 3, C_S, 3'b000);
        add_op(32'h707F, 32'h0013, 3, C_I, 0);
        add_op(32'h707F, 32'h2013, 10, C_I, 0);
        add_op(32'h707F, 32'h3013, 11, C_I, 0);
        add_op(32'h707F, 32'h4013, 12, C_I, 0);
        add_op(32'h707F, 32'h6013, 13, C_I, 0);
        add_op(32'h707F, 32'h7013, 14, C_I, 0);
        add_op(32'hFE00707F, 32'h00001013, 15, C_SH, 0);
        add_op(32'hFE00707F, 32'h00005013, 16, C_SH, 0);
        add_op(32'hFE00707F, 32'h40005013, 17, C_SH, 0);
        add_op(32'hFE00707F, 32'h00000033, 3, C_R, 0);
        add_op(32'hFE00707F, 32'h40000033, 4, C_R, 0);
        add_op(32'hFE00707F, 32'h00001033, 15, C_R, 0);
        add_op(32'hFE00707F, 32'h00002033, 10, C_R, 0);
        add_op(32'hFE00707F, 32'h00003033, 11, C_R, 0);
        add_op(32'hFE00707F, 32'h00004033, 12, C_R, 0);
        add_op(32'hFE00707F, 32'h00005033, 16, C_R, 0);
        add_op(32'hFE00707F, 32'h40005033, 17, C_R, 0);
        add_op(32'hFE00707F, 32'h00006033, 13, C_R, 0);
        add_op(32'hFE00707F, 32'h00007033, 14, C_R, 0);
        for (int f = 0; f < 8; f++)
            add_op(32'hFE00707F, 32'h02000033 | (f << 12), 18 + f, C_M, 0);
    endtask

    function automatic bund_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit m_on);
        bund_t b;
        int hit;
        b = '0;
        hit = -1;
        b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
        foreach (optab[i])
            if (hit < 0 && (w & optab[i].mask) == optab[i].match) hit = i;
        if (hit < 0 || (optab[hit].cls == C_M && !m_on)) begin
            b.ill = 1'b1;
            return b;
        end
        b.alu = optab[hit].alu[4:0];
        case (optab[hit].cls)
            C_U:  begin b.regw = 1; b.alusrc = 1; b.imm = 6'b000010; end
            C_J:  begin b.regw = 1; b.alusrc = 1; b.jal = 1; b.wd = 2; b.imm = 6'b000001; end
            C_JR: begin b.regw = 1; b.alusrc = 1; b.jalr = 1; b.wd = 2; b.imm = 6'b010000; end
            C_B:  begin b.branch = 1; b.imm = 6'b000100; b.rd = 0; end
            C_L:  begin b.regw = 1; b.alusrc = 1; b.memtoreg = 1; b.wd = 1; b.imm = 6'b010000; b.dm = optab[hit].dm; end
            C_S:  begin b.memw = 1; b.alusrc = 1; b.imm = 6'b001000; b.dm = optab[hit].dm; b.rd = 0; end
            C_I:  begin b.regw = 1; b.alusrc = 1; b.imm = 6'b010000; end
            C_SH: begin b.regw = 1; b.alusrc = 1; b.imm = 6'b100000; end
            default: b.regw = 1;
        endcase
        return b;
    endfunction

    function automatic bit reads_rs1(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads_rs2(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int r;
        op_t o;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            w = $urandom;
        end else begin
            o = optab[$urandom_range(0, optab.size() - 1)];
            w = ($urandom & ~o.mask) | o.match;
            if (r == 1) w[31:25] = 7'($urandom);
        end
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] p,
                         input bit rdy, input bit fl);
        bit hz_e[2];
        bit rdy_e[2];
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = p; out_ready = rdy; flush = fl;
        #1;
        for (int d = 0; d < 2; d++) begin
            hz_e[d] = m_valid[d] && m_b[d].memtoreg && (m_b[d].rd != 0) && v &&
                      ((reads_rs1(ins) && ins[19:15] == m_b[d].rd) ||
                       (reads_rs2(ins) && ins[24:20] == m_b[d].rd));
            rdy_e[d] = fl || ((!m_valid[d] || rdy) && !hz_e[d]);
            chk_val($sformatf("in_ready[%0d]", d), 128'(obs_rdy[d]), 128'(rdy_e[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (fl) begin
                m_valid[d] = 0; m_b[d] = '0;
            end else if (v && rdy_e[d]) begin
                m_valid[d] = 1; m_b[d] = ref_decode(ins, p, en_m[d]);
            end else if (rdy) begin
                m_valid[d] = 0; m_b[d] = '0;
                if (hz_e[d] && m_cnt[d] < cnt_max[d]) m_cnt[d]++;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_val($sformatf("bundle[%0d] pc=%0h instr=%0h", d, p, ins),
                    128'(obs_v[d]), 128'({m_valid[d], m_b[d]}));
            chk_val($sformatf("bubble_cnt[%0d]", d), 128'(obs_cnt[d]), 128'(m_cnt[d]));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_b[d] = '0; m_cnt[d] = 0;
            chk_val($sformatf("%s bundle[%0d]", tag, d), 128'(obs_v[d]), 128'(0));
            chk_val($sformatf("%s cnt[%0d]", tag, d), 128'(obs_cnt[d]), 128'(0));
            chk_val($sformatf("%s in_ready[%0d]", tag, d), 128'(obs_rdy[d]), 128'(1));
        end
    endtask

    initial begin
        build_table();
        #12;
        check_reset("por");
        @(negedge clk);
        rstn = 1'b1;

        cycle(1, I_ADD, 32'h100, 1, 0);
        chk_val("add valid", 128'(ifa.out_valid), 128'(1));
        chk_val("add alu", 128'(ifa.out_ALUOp), 128'(3));
        chk_val("add regwrite", 128'(ifa.out_RegWrite), 128'(1));
        chk_val("add alusrc", 128'(ifa.out_ALUSrc), 128'(0));
        chk_val("add rd", 128'(ifa.out_rd), 128'(3));
        chk_val("add immop", 128'(ifa.out_IMMOp), 128'(0));

        cycle(1, I_LW0, 32'h104, 1, 0);
        cycle(1, I_ADDX0, 32'h108, 1, 0);
        chk_val("lw x0 no bubble pc", 128'(ifa.out_pc), 128'(32'h108));
        chk_val("lw x0 cnt", 128'(cnt_a), 128'(0));

        cycle(1, I_LW5, 32'h10C, 1, 0);
        cycle(1, I_ADD6, 32'h110, 1, 0);
        chk_val("load-use bubble valid", 128'(ifa.out_valid), 128'(0));
        cycle(1, I_ADD6, 32'h110, 1, 0);
        chk_val("load-use add pc", 128'(ifa.out_pc), 128'(32'h110));
        chk_val("load-use cnt", 128'(cnt_a), 128'(1));

        cycle(1, I_MUL, 32'h114, 1, 0);
        chk_val("mul alu M on", 128'(ifa.out_ALUOp), 128'(18));
        chk_val("mul illegal M on", 128'(ifa.out_illegal), 128'(0));
        chk_val("mul illegal M off", 128'(ifb.out_illegal), 128'(1));
        chk_val("mul regwrite M off", 128'(ifb.out_RegWrite), 128'(0));

        cycle(1, I_ADD, 32'h118, 1, 0);
        cycle(1, I_LW5, 32'h11C, 0, 0);
        chk_val("stall hold pc", 128'(ifa.out_pc), 128'(32'h118));
        chk_val("stall in_ready", 128'(ifa.in_ready), 128'(0));
        cycle(1, I_LW5, 32'h120, 0, 1);
        chk_val("flush valid", 128'(ifa.out_valid), 128'(0));
        cycle(1, I_LW5, 32'h124, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        for (int k = 0; k < 3; k++) begin
            cycle(1, I_LW5, 32'h200 + 8 * k, 1, 0);
            cycle(1, I_ADD6, 32'h204 + 8 * k, 1, 0);
            cycle(1, I_ADD6, 32'h204 + 8 * k, 1, 0);
        end
        chk_val("sat cnt CNT_W=2", 128'(cnt_b), 128'(3));
        chk_val("sat cnt CNT_W=16", 128'(cnt_a), 128'(4));

        for (int k = 0; k < 1500; k++)
            cycle($urandom_range(0, 9) < 8, rand_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

        #2;
        rstn = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check_reset("midstream reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int k = 0; k < 500; k++)
            cycle($urandom_range(0, 9) < 8, rand_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
